// File: rtl/dma_app_pkg.sv
// Shared helpers for the DMA_APP stream path: width math and counter widths.
// Everything here is elaboration-time only.
package dma_app_pkg;

  localparam int DROP_W = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int ratio_of(input int ow, input int iw);
    return ow / iw;
  endfunction

  // Bits needed to report 1..ratio valid lanes.
  function automatic int lane_cnt_w(input int ratio);
    return clog2(ratio) + 1;
  endfunction

  // Bits needed to index lanes 0..ratio-1.
  function automatic int lane_idx_w(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: rd_data always shows the head entry.
// full/empty derive only from registered pointers, so a same-cycle pop never frees a slot.
module sync_fifo_fwft
  import dma_app_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo_fwft: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit separates the full and empty cases when addresses match.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_stream_upsizer.sv
// Packs IW-bit beats into OW-bit words with explicit/idle flush, lane-count reporting
// and drop accounting; closed words queue in a FWFT FIFO towards the DMA.
module uart_stream_upsizer
  import dma_app_pkg::*;
#(
  parameter int IW         = 8,
  parameter int OW         = 256,
  parameter int MSB_FIRST  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    sys_clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IW-1:0]           in_data,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OW-1:0]           out_data,
  output logic [clog2(OW/IW):0]   out_lanes,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int RATIO = ratio_of(OW, IW);
  localparam int LW    = lane_cnt_w(RATIO);
  localparam int LIW   = lane_idx_w(RATIO);
  localparam int TW    = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam int FW    = OW + LW;

  localparam logic [LIW-1:0] LAST_LANE = LIW'(RATIO - 1);
  localparam logic [TW-1:0]  IDLE_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0]  IDLE_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  if ((OW % IW) != 0 || (OW / IW) < 2) begin : g_bad_width
    $error("uart_stream_upsizer: OW must be a multiple of IW with OW/IW >= 2");
  end

  logic [OW-1:0]     acc;
  logic [LIW-1:0]    lane;
  logic [TW-1:0]     idle;
  logic              pending;
  logic [DROP_W-1:0] drop_q;

  logic [OW-1:0]     acc_merged;
  logic [LW-1:0]     close_lanes;
  logic              accept;
  logic              lane_nz;
  logic              timeout_hit;
  logic              close_req;
  logic              close_full;
  logic              close_want;
  logic              do_close;
  int                beat_base;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_rd;
  logic [FW-1:0]     fifo_rd_data;

  // Stall only when a close would be forced into a full FIFO.
  assign in_ready = !(fifo_full && ((lane == LAST_LANE) || pending));
  assign accept   = in_valid && in_ready;
  assign lane_nz  = (lane != '0);

  // The merged word is what gets pushed, so a beat arriving with a flush is included.
  always_comb begin
    beat_base   = (MSB_FIRST != 0) ? (OW - IW - int'(lane) * IW) : int'(lane) * IW;
    acc_merged  = acc;
    if (accept) acc_merged[beat_base +: IW] = in_data;
    close_lanes = LW'(lane) + LW'(accept);
    timeout_hit = (TIMEOUT != 0) && lane_nz && !accept && (idle == IDLE_LAST);
    close_req   = flush || pending || timeout_hit;
    close_full  = accept && (lane == LAST_LANE);
    close_want  = close_full || (close_req && (lane_nz || accept));
    do_close    = close_want && !fifo_full;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      lane <= '0;
    end else if (do_close) begin
      acc  <= '0;
      lane <= '0;
    end else if (accept) begin
      acc  <= acc_merged;
      lane <= lane + 1'b1;
    end
  end

  // A close blocked by a full FIFO is remembered until a slot frees up.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (do_close) begin
      pending <= 1'b0;
    end else if (close_want) begin
      pending <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle <= '0;
    end else if (accept || do_close) begin
      idle <= '0;
    end else if (lane_nz && (idle != IDLE_MAX)) begin
      idle <= idle + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
    end else if (in_valid && !in_ready && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  assign drop_cnt = drop_q;

  sync_fifo_fwft #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .wr_en   (do_close),
    .wr_data ({close_lanes, acc_merged}),
    .full    (fifo_full),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty)
  );

  // Storage is not reset, so the head is masked to zero while nothing is queued.
  assign out_valid = !fifo_empty;
  assign fifo_rd   = out_valid && out_ready;
  assign out_data  = fifo_empty ? '0 : fifo_rd_data[OW-1:0];
  assign out_lanes = fifo_empty ? '0 : fifo_rd_data[FW-1:OW];

endmodule

// File: tb/tb_uart_stream_upsizer.sv
// Directed bench for uart_stream_upsizer: four instances cover default packing,
// LSB-first lane order, a 16-cycle timeout and a disabled timeout.
module tb_uart_stream_upsizer;

  logic        sys_clk;
  logic        rst_n;
  logic        in_valid_v  [4];
  logic        in_ready_v  [4];
  logic [7:0]  in_data_v   [4];
  logic        flush_v     [4];
  logic        out_valid_v [4];
  logic        out_ready_v [4];
  logic [255:0] out_data_v [4];
  logic [5:0]  out_lanes_v [4];
  logic [15:0] drop_v      [4];

  int checks;
  int errors;

  uart_stream_upsizer #(.IW(8), .OW(256), .MSB_FIRST(1), .FIFO_DEPTH(4), .TIMEOUT(1024)) dut_def (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data_v[0]), .flush(flush_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready_v[0]), .out_data(out_data_v[0]), .out_lanes(out_lanes_v[0]),
    .drop_cnt(drop_v[0]));

  uart_stream_upsizer #(.IW(8), .OW(256), .MSB_FIRST(0), .FIFO_DEPTH(4), .TIMEOUT(1024)) dut_lsb (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data_v[1]), .flush(flush_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready_v[1]), .out_data(out_data_v[1]), .out_lanes(out_lanes_v[1]),
    .drop_cnt(drop_v[1]));

  uart_stream_upsizer #(.IW(8), .OW(256), .MSB_FIRST(1), .FIFO_DEPTH(4), .TIMEOUT(16)) dut_to16 (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .in_data(in_data_v[2]), .flush(flush_v[2]), .out_valid(out_valid_v[2]),
    .out_ready(out_ready_v[2]), .out_data(out_data_v[2]), .out_lanes(out_lanes_v[2]),
    .drop_cnt(drop_v[2]));

  uart_stream_upsizer #(.IW(8), .OW(256), .MSB_FIRST(1), .FIFO_DEPTH(4), .TIMEOUT(0)) dut_to0 (
    .sys_clk(sys_clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
    .in_data(in_data_v[3]), .flush(flush_v[3]), .out_valid(out_valid_v[3]),
    .out_ready(out_ready_v[3]), .out_data(out_data_v[3]), .out_lanes(out_lanes_v[3]),
    .drop_cnt(drop_v[3]));

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Word holding consecutive byte values first, first+1, ... in the first nlanes lanes.
  function automatic logic [255:0] make_word(input int first, input int nlanes, input int msb);
    logic [255:0] w;
    logic [7:0]   b;
    w = '0;
    for (int i = 0; i < nlanes; i++) begin
      b = 8'(first + i);
      if (msb != 0) w[255 - 8*i -: 8] = b;
      else          w[8*i +: 8]       = b;
    end
    return w;
  endfunction

  // Presents n consecutive byte values, one per cycle; in_valid is left high.
  task automatic send_beats(input int d, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      in_valid_v[d] = 1'b1;
      in_data_v[d]  = 8'(first + i);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 4; d++) begin
      in_valid_v[d]  = 1'b0;
      in_data_v[d]   = '0;
      flush_v[d]     = 1'b0;
      out_ready_v[d] = 1'b0;
    end
    repeat (2) @(negedge sys_clk);
    checks++;
    if (in_ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready_v[0]); end
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid_v[0]); end
    checks++;
    if (out_data_v[0] !== '0) begin errors++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data_v[0]); end
    checks++;
    if (out_lanes_v[0] !== 6'd0) begin errors++; $display("[TB] FAIL reset_out_lanes: got %0d expected 0", out_lanes_v[0]); end
    checks++;
    if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_v[0]); end
    rst_n = 1'b1;
  endtask

  task automatic test_full_words();
    logic [255:0] exp;
    exp = make_word(0, 32, 1);
    out_ready_v[0] = 1'b1;
    send_beats(0, 0, 31);
    @(negedge sys_clk);
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_early_valid: got %b expected 0", out_valid_v[0]); end
    in_data_v[0] = 8'd31;
    @(negedge sys_clk);
    in_valid_v[0] = 1'b0;
    checks++;
    if (out_valid_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL full_valid: got %b expected 1", out_valid_v[0]); end
    checks++;
    if (out_lanes_v[0] !== 6'd32) begin errors++; $display("[TB] FAIL full_lanes: got %0d expected 32", out_lanes_v[0]); end
    checks++;
    if (out_data_v[0] !== exp) begin errors++; $display("[TB] FAIL full_data: got %h expected %h", out_data_v[0], exp); end
    @(negedge sys_clk);
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL full_popped: got %b expected 0", out_valid_v[0]); end
  endtask

  task automatic test_lane_order();
    logic [255:0] exp;
    exp = make_word(0, 32, 0);
    out_ready_v[1] = 1'b1;
    send_beats(1, 0, 32);
    @(negedge sys_clk);
    in_valid_v[1] = 1'b0;
    checks++;
    if (out_valid_v[1] !== 1'b1) begin errors++; $display("[TB] FAIL lsb_valid: got %b expected 1", out_valid_v[1]); end
    checks++;
    if (out_data_v[1][7:0] !== 8'h00) begin errors++; $display("[TB] FAIL lsb_low_byte: got %h expected 00", out_data_v[1][7:0]); end
    checks++;
    if (out_data_v[1][255:248] !== 8'h1F) begin errors++; $display("[TB] FAIL lsb_high_byte: got %h expected 1f", out_data_v[1][255:248]); end
    checks++;
    if (out_data_v[1] !== exp) begin errors++; $display("[TB] FAIL lsb_data: got %h expected %h", out_data_v[1], exp); end
    @(negedge sys_clk);
  endtask

  task automatic test_explicit_flush();
    int seen;
    logic [255:0] exp;
    out_ready_v[0] = 1'b1;
    send_beats(0, 8'hA1, 3);
    @(negedge sys_clk);
    in_valid_v[0] = 1'b0;
    flush_v[0]    = 1'b1;
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL flush_early_valid: got %b expected 0", out_valid_v[0]); end
    @(negedge sys_clk);
    flush_v[0] = 1'b0;
    exp = make_word(8'hA1, 3, 1);
    checks++;
    if (out_valid_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL flush_valid: got %b expected 1", out_valid_v[0]); end
    checks++;
    if (out_lanes_v[0] !== 6'd3) begin errors++; $display("[TB] FAIL flush_lanes: got %0d expected 3", out_lanes_v[0]); end
    checks++;
    if (out_data_v[0][255:232] !== 24'hA1A2A3) begin errors++; $display("[TB] FAIL flush_top_bytes: got %h expected a1a2a3", out_data_v[0][255:232]); end
    checks++;
    if (out_data_v[0] !== exp) begin errors++; $display("[TB] FAIL flush_data: got %h expected %h", out_data_v[0], exp); end
    @(negedge sys_clk);
    flush_v[0] = 1'b1;
    @(negedge sys_clk);
    flush_v[0] = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid_v[0] !== 1'b0) seen++;
      @(negedge sys_clk);
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL flush_empty_noop: got %0d valid cycles expected 0", seen); end
    // Flush presented together with the second beat.
    send_beats(0, 8'hB1, 2);
    flush_v[0] = 1'b1;
    @(negedge sys_clk);
    in_valid_v[0] = 1'b0;
    flush_v[0]    = 1'b0;
    exp = make_word(8'hB1, 2, 1);
    checks++;
    if (out_lanes_v[0] !== 6'd2) begin errors++; $display("[TB] FAIL flush_beat_lanes: got %0d expected 2", out_lanes_v[0]); end
    checks++;
    if (out_data_v[0] !== exp) begin errors++; $display("[TB] FAIL flush_beat_data: got %h expected %h", out_data_v[0], exp); end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    int early;
    logic [255:0] exp;
    out_ready_v[2] = 1'b1;
    send_beats(2, 8'h50, 5);
    early = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge sys_clk);
      in_valid_v[2] = 1'b0;
      if (out_valid_v[2] !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin errors++; $display("[TB] FAIL timeout_early: got %0d valid cycles expected 0", early); end
    @(negedge sys_clk);
    exp = make_word(8'h50, 5, 1);
    checks++;
    if (out_valid_v[2] !== 1'b1) begin errors++; $display("[TB] FAIL timeout_valid: got %b expected 1", out_valid_v[2]); end
    checks++;
    if (out_lanes_v[2] !== 6'd5) begin errors++; $display("[TB] FAIL timeout_lanes: got %0d expected 5", out_lanes_v[2]); end
    checks++;
    if (out_data_v[2] !== exp) begin errors++; $display("[TB] FAIL timeout_data: got %h expected %h", out_data_v[2], exp); end
    @(negedge sys_clk);
  endtask

  task automatic test_timeout_disabled();
    int seen;
    out_ready_v[3] = 1'b1;
    send_beats(3, 8'h60, 5);
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge sys_clk);
      in_valid_v[3] = 1'b0;
      if (out_valid_v[3] !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("[TB] FAIL notimeout_idle: got %0d valid cycles expected 0", seen); end
    flush_v[3] = 1'b1;
    @(negedge sys_clk);
    flush_v[3] = 1'b0;
    checks++;
    if (out_lanes_v[3] !== 6'd5) begin errors++; $display("[TB] FAIL notimeout_flush_lanes: got %0d expected 5", out_lanes_v[3]); end
    @(negedge sys_clk);
  endtask

  task automatic test_backpressure();
    int not_ready;
    logic [255:0] exp;
    out_ready_v[0] = 1'b0;
    not_ready = 0;
    for (int n = 0; n < 159; n++) begin
      @(negedge sys_clk);
      if (in_ready_v[0] !== 1'b1) not_ready++;
      in_valid_v[0] = 1'b1;
      in_data_v[0]  = 8'(n);
    end
    checks++;
    if (not_ready != 0) begin errors++; $display("[TB] FAIL bp_accept_159: got %0d stalled cycles expected 0", not_ready); end
    @(negedge sys_clk);
    in_data_v[0] = 8'd159;
    checks++;
    if (in_ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low: got %b expected 0", in_ready_v[0]); end
    checks++;
    if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL bp_drop_before: got %0d expected 0", drop_v[0]); end
    repeat (4) @(negedge sys_clk);
    checks++;
    if (drop_v[0] !== 16'd4) begin errors++; $display("[TB] FAIL bp_drop_held: got %0d expected 4", drop_v[0]); end
    out_ready_v[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge sys_clk);
      exp = make_word(32*k, 32, 1);
      checks++;
      if (out_valid_v[0] !== 1'b1 || out_lanes_v[0] !== 6'd32 || out_data_v[0] !== exp) begin
        errors++;
        $display("[TB] FAIL bp_drain_word%0d: got valid=%b lanes=%0d data=%h expected valid=1 lanes=32 data=%h",
                 k, out_valid_v[0], out_lanes_v[0], out_data_v[0], exp);
      end
      if (k == 1) begin
        checks++;
        if (drop_v[0] !== 16'd5) begin errors++; $display("[TB] FAIL bp_drop_final: got %0d expected 5", drop_v[0]); end
        checks++;
        if (in_ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_back: got %b expected 1", in_ready_v[0]); end
      end
      if (k == 2) in_valid_v[0] = 1'b0;
    end
    @(negedge sys_clk);
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_drained: got %b expected 0", out_valid_v[0]); end
    checks++;
    if (drop_v[0] !== 16'd5) begin errors++; $display("[TB] FAIL bp_drop_stable: got %0d expected 5", drop_v[0]); end
  endtask

  task automatic test_reset_mid();
    int extra;
    logic [255:0] exp;
    out_ready_v[0] = 1'b0;
    send_beats(0, 8'h80, 74);
    @(negedge sys_clk);
    in_valid_v[0] = 1'b0;
    checks++;
    if (out_valid_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_words_queued: got %b expected 1", out_valid_v[0]); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %b expected 0", out_valid_v[0]); end
    checks++;
    if (drop_v[0] !== 16'd0) begin errors++; $display("[TB] FAIL rst_async_drop: got %0d expected 0", drop_v[0]); end
    checks++;
    if (out_data_v[0] !== '0 || out_lanes_v[0] !== 6'd0) begin
      errors++;
      $display("[TB] FAIL rst_async_outputs: got data=%h lanes=%0d expected 0", out_data_v[0], out_lanes_v[0]);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    out_ready_v[0] = 1'b1;
    send_beats(0, 8'hC0, 32);
    @(negedge sys_clk);
    in_valid_v[0] = 1'b0;
    exp = make_word(8'hC0, 32, 1);
    checks++;
    if (out_valid_v[0] !== 1'b1 || out_lanes_v[0] !== 6'd32 || out_data_v[0] !== exp) begin
      errors++;
      $display("[TB] FAIL rst_fresh_word: got valid=%b lanes=%0d data=%h expected valid=1 lanes=32 data=%h",
               out_valid_v[0], out_lanes_v[0], out_data_v[0], exp);
    end
    extra = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge sys_clk);
      if (out_valid_v[0] !== 1'b0) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("[TB] FAIL rst_single_word: got %0d extra valid cycles expected 0", extra); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_full_words();
    test_lane_order();
    test_explicit_flush();
    test_timeout();
    test_timeout_disabled();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
